// File: rtl/universal_shift_reg_param.sv
// Parametrised universal shift register with hold/shift/load/rotate/arith-shift ops
// and a burst engine. Optional parity output when SHREG_PARITY_EN is defined.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | single-step ops on en, burst requests accepted on start
// ST_RUN   | burst in progress: one op of bmode per cycle until done

module universal_shift_reg_param #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       mode,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic [WIDTH-1:0] p_din,
  input  logic             s_left_din,
  input  logic             s_right_din,
  output logic [WIDTH-1:0] p_dout,
  output logic             s_left_dout,
  output logic             s_right_dout,
  output logic             busy,
`ifdef SHREG_PARITY_EN
  output logic             done,
  output logic             parity
`else
  output logic             done
`endif
);

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_SHR  = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_LOAD = 3'd3;
  localparam logic [2:0] MODE_ROR  = 3'd4;
  localparam logic [2:0] MODE_ROL  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [2:0]       bmode_q, bmode_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [WIDTH-1:0] q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             op_go;
  logic [2:0]       op_sel;

  function automatic logic [WIDTH-1:0] apply_op(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic [WIDTH-1:0] load_val,
    input logic             sl_in,
    input logic             sr_in
  );
    logic [WIDTH-1:0] res;
    res = cur;
    case (op)
      MODE_HOLD: res = cur;
      MODE_SHR:  res = {sr_in, cur[WIDTH-1:1]};
      MODE_SHL:  res = {cur[WIDTH-2:0], sl_in};
      MODE_LOAD: res = load_val;
      MODE_ROR:  res = {cur[0], cur[WIDTH-1:1]};
      MODE_ROL:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
      MODE_ASR:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default:   res = cur;
    endcase
    return res;
  endfunction

  always_comb begin
    state_d     = state_q;
    bmode_d     = bmode_q;
    remaining_d = remaining_q;
    op_go       = 1'b0;
    op_sel      = mode;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (count != CNT_ZERO) begin
            state_d     = ST_RUN;
            bmode_d     = mode;
            remaining_d = count;
          end else begin
            done_d = 1'b1;
          end
        end else if (en) begin
          op_go = 1'b1;
        end
      end
      ST_RUN: begin
        op_go       = 1'b1;
        op_sel      = bmode_q;
        remaining_d = remaining_q - CNT_ONE;
        if (remaining_q == CNT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    q_d    = op_go ? apply_op(op_sel, q, p_din, s_left_din, s_right_din) : q;
    // busy is registered, so it tracks the state we are about to enter
    busy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bmode_q     <= MODE_HOLD;
      remaining_q <= CNT_ZERO;
      q           <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bmode_q     <= bmode_d;
      remaining_q <= remaining_d;
      q           <= q_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

`ifdef SHREG_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= ^q_d;
    end
  end

  assign parity = parity_q;
`endif

  assign p_dout       = q;
  assign s_left_dout  = q[WIDTH-1];
  assign s_right_dout = q[0];
  assign busy         = busy_q;
  assign done         = done_q;

endmodule
